afisare_n_cifre: RTL
====================

# afisare_n_cifre

Parametrised multiplexed seven-segment driver for the car's dashboard display, the next generation of the fixed 4-digit driver. It scans NUM_DIGITS common-selected digits with a programmable slot prescaler and shows one of three frame contents: a BCD number with leading-zero suppression, a blinking turn-indicator pattern, or the stop pattern. It adds PWM brightness, per-slot anti-ghosting dead time, and a tear-free input snapshot taken once per frame. It sits between the speed/turn/stop logic and the board display pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned, 2..8.
- PRESCALE, 50000: clock cycles per digit slot; multiple of 16, ≥ 16.
- BLINK_FRAMES, 64: frames per blink half-period, ≥ 1.
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stop  in  1  stop request; overrides the turn signals.
- semnal_stanga  in  1  left turn signal.
- semnal_dreapta  in  1  right turn signal.
- bcd_in  in  4*NUM_DIGITS  number to show; nibble [3:0] is units (rightmost).
- brightness  in  4  PWM level: 0 is dimmest, 15 is full.
- dig  out  NUM_DIGITS  one-hot digit select, active-high; bit NUM_DIGITS-1 is D1 (leftmost).
- seg  out  7  {a,b,c,d,e,f,g}, active-low (0 = lit).
- frame_start  out  1  one-cycle pulse when slot 0 of a new frame begins.

## Operation
- **Counters:**
  - slot_cnt: 0..PRESCALE-1.
  - idx: 0..NUM_DIGITS-1; advances when slot_cnt wraps. idx 0 is the leftmost digit.
  - frame_cnt: 0..BLINK_FRAMES-1; advances at each frame boundary.
  - blink_phase: toggles when frame_cnt wraps.
- **Frame boundary:** the edge where slot_cnt = PRESCALE-1 and idx = NUM_DIGITS-1. At that edge the snapshot registers load stop, semnal_stanga, semnal_dreapta, bcd_in and brightness. The display uses only snapshot values; mid-frame input changes are invisible until the next frame.
- **Mode priority:** snapshot stop → STOP. Otherwise exactly one turn signal set → LEFT or RIGHT. Otherwise (none set, or both set) → NUMBER.
- **Glyphs:**
  - Codes 0–9 are the decimal digits.
  - STANGA lights a,d,e,f,g.
  - DREAPTA lights a,b,c,d,g.
  - DASH lights g only.
  - BLANK lights nothing.
- **NUMBER:**
  - Digit at idx shows nibble NUM_DIGITS-1-idx.
  - Nibbles > 9 show DASH.
  - Leading zeros are shown BLANK, scanning from the most significant nibble until the first nonzero nibble.
  - The units digit is never suppressed.
- **RIGHT:** the rightmost digit shows DREAPTA when blink_phase = 1 and BLANK otherwise; all other digits show DASH.
- **LEFT:** the leftmost digit shows STANGA or BLANK on the same blink rule; all other digits show DASH.
- **STOP:** every digit shows 8 (all segments lit), no blinking.
- **Digit enable:**
  - duty = (brightness+1)·PRESCALE/16.
  - dig[NUM_DIGITS-1-idx] is asserted only while 1 ≤ slot_cnt < duty; otherwise dig = 0.
  - slot_cnt = 0 is always dark (dead time between digits).
- **Reset values:**
  - dig = 0, seg = 7'h7F, frame_start = 0.
  - slot_cnt = 0, idx = 0, frame_cnt = 0, blink_phase = 1.
  - Snapshot is NUMBER with all-BLANK content and brightness 15.
- Asserting reset mid-frame blanks the outputs asynchronously. Scanning restarts from idx 0 on release.

## Timing
- dig, seg and frame_start are registered and reflect counter state with 1 cycle of latency.
- First frame after reset release is blank. Inputs present at the first frame boundary (cycle PRESCALE·NUM_DIGITS after release) are shown from the following frame.
- Input-to-display latency is 1 to 2 frames.
- frame_start is high for exactly the 1 cycle after each frame-boundary edge (output latency included). It does not pulse for the first frame after reset.
- Blink half-period is BLINK_FRAMES·NUM_DIGITS·PRESCALE cycles.
- frame_cnt runs in every mode, so blink phase is continuous across mode changes.
- At brightness 15 each digit is lit PRESCALE-1 of every PRESCALE cycles.

## Structure
- Package afisare_pkg:
  - Glyph code constants: DIG_0..DIG_9, GLYPH_STANGA = 4'hB, GLYPH_DREAPTA = 4'hA, GLYPH_DASH = 4'hC, GLYPH_BLANK = 4'hD.
  - Mode enumeration: NUMBER, LEFT, RIGHT, STOP.
  - Active-low segment constant SEG_OFF = 7'h7F.
- Sub-module decodor_7seg: 4-bit glyph code to 7-bit active-low segments, combinational. Unused codes decode to BLANK.
- Top level holds the counters, the snapshot, the leading-zero mask, glyph selection and the output registers.

## Test plan
- Reset held, then released mid-bench: dig = 0, seg = 7'h7F throughout reset and the first frame. Assert reset again mid-slot: outputs clear in the same cycle without waiting for a clock.
- NUM_DIGITS=4, PRESCALE=16, brightness=15, bcd_in=16'h0042: second frame scans BLANK, BLANK, 4, 2. dig steps 1000, 0100, 0010, 0001, each high for 15 of 16 cycles. frame_start pulses every 64 cycles.
- bcd_in=16'h0000 shows BLANK, BLANK, BLANK, 0. bcd_in=16'h0A05 shows BLANK, DASH, 0, 5.
- semnal_dreapta=1, BLINK_FRAMES=2: leftmost three digits show DASH; rightmost alternates DREAPTA/BLANK every 2 frames. Setting both turn signals reverts to NUMBER.
- stop=1 with semnal_stanga=1: all digits show seg = 7'h00. Toggling stop mid-frame does not change the current frame.
- NUM_DIGITS=6, PRESCALE=16, brightness=3: duty = 4, so each dig bit is high 3 cycles per slot. Six distinct one-hot values appear per 96-cycle frame.

Source files
------------

// File: rtl/afisare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afisare_pkg
// Description : Shared glyph codes, display modes and segment constants for
//               the multiplexed seven-segment dashboard driver.
// Revision    : 1.0 - initial release
// ============================================================================
package afisare_pkg;

  // Glyph codes 0..9 are the decimal digits themselves
  localparam logic [3:0] DIG_0 = 4'h0;
  localparam logic [3:0] DIG_1 = 4'h1;
  localparam logic [3:0] DIG_2 = 4'h2;
  localparam logic [3:0] DIG_3 = 4'h3;
  localparam logic [3:0] DIG_4 = 4'h4;
  localparam logic [3:0] DIG_5 = 4'h5;
  localparam logic [3:0] DIG_6 = 4'h6;
  localparam logic [3:0] DIG_7 = 4'h7;
  localparam logic [3:0] DIG_8 = 4'h8;
  localparam logic [3:0] DIG_9 = 4'h9;

  localparam logic [3:0] GLYPH_DREAPTA = 4'hA;
  localparam logic [3:0] GLYPH_STANGA  = 4'hB;
  localparam logic [3:0] GLYPH_DASH    = 4'hC;
  localparam logic [3:0] GLYPH_BLANK   = 4'hD;

  // Segment bus is {a,b,c,d,e,f,g}, active-low
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    NUMBER = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    STOP   = 2'd3
  } mode_t;

  // Stop wins; a single turn signal selects its side; none or both shows the number
  function automatic mode_t select_mode(input logic stop_req,
                                        input logic left_req,
                                        input logic right_req);
    mode_t m;
    m = NUMBER;
    if (stop_req) begin
      m = STOP;
    end else if (left_req && !right_req) begin
      m = LEFT;
    end else if (right_req && !left_req) begin
      m = RIGHT;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/afisare_n_cifre_decodor_7seg.sv
`default_nettype none
// ============================================================================
// Module      : decodor_7seg
// Description : Combinational glyph-code to active-low seven-segment decoder.
//               Codes without a glyph decode to an unlit digit.
// Revision    : 1.0 - initial release
// ============================================================================
module decodor_7seg
  import afisare_pkg::*;
(
  input  logic [3:0] i_glyph,
  output logic [6:0] o_seg
);

  // Glyph lookup; segments are {a,b,c,d,e,f,g}, 0 = lit
  always_comb begin
    o_seg = SEG_OFF;
    case (i_glyph)
      DIG_0:         o_seg = 7'h01;
      DIG_1:         o_seg = 7'h4F;
      DIG_2:         o_seg = 7'h12;
      DIG_3:         o_seg = 7'h06;
      DIG_4:         o_seg = 7'h4C;
      DIG_5:         o_seg = 7'h24;
      DIG_6:         o_seg = 7'h20;
      DIG_7:         o_seg = 7'h0F;
      DIG_8:         o_seg = 7'h00;
      DIG_9:         o_seg = 7'h04;
      GLYPH_DREAPTA: o_seg = 7'h06;
      GLYPH_STANGA:  o_seg = 7'h30;
      GLYPH_DASH:    o_seg = 7'h7E;
      default:       o_seg = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/afisare_n_cifre.sv
`default_nettype none
// ============================================================================
// Module      : afisare_n_cifre
// Description : NUM_DIGITS multiplexed seven-segment driver with slot
//               prescaler, per-frame input snapshot, leading-zero blanking,
//               blinking turn indicators, stop pattern and PWM brightness.
// Revision    : 1.0 - initial release
// ============================================================================
module afisare_n_cifre
  import afisare_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stop,
  input  logic                    semnal_stanga,
  input  logic                    semnal_dreapta,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [6:0]              seg,
  output logic                    frame_start
);

  localparam int SLOT_W  = $clog2(PRESCALE);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam int               c_duty_step  = PRESCALE / 16;
  localparam logic [SLOT_W-1:0]  c_slot_last  = SLOT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0]  c_slot_one   = SLOT_W'(1);
  localparam logic [IDX_W-1:0]   c_idx_last   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]   c_idx_one    = IDX_W'(1);
  localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] c_frame_one  = FRAME_W'(1);

  // Scan counters
  logic [SLOT_W-1:0]  r_slot_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_blink_phase;

  // Per-frame snapshot; r_snap_valid stays low until the first frame boundary
  // so the frame right after reset is dark and blank
  logic                    r_snap_valid;
  mode_t                   r_snap_mode;
  logic [4*NUM_DIGITS-1:0] r_snap_bcd;
  logic [3:0]              r_snap_bright;

  // Output registers
  logic [NUM_DIGITS-1:0] r_dig;
  logic [6:0]            r_seg;
  logic                  r_frame_start;

  logic                  w_slot_wrap;
  logic                  w_frame_end;
  logic [IDX_W-1:0]      w_pos;
  logic [3:0]            w_nibble;
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic [3:0]            w_glyph;
  logic [6:0]            w_seg_next;
  logic [31:0]           w_duty;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_dig_next;

  assign w_slot_wrap = (r_slot_cnt == c_slot_last);
  assign w_frame_end = w_slot_wrap && (r_idx == c_idx_last);

  // idx 0 is the leftmost digit, which carries the most significant nibble
  assign w_pos    = c_idx_last - r_idx;
  assign w_nibble = r_snap_bcd[4*w_pos +: 4];

  // Slot, digit and frame counters; blink phase flips when the frame count wraps
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot_cnt    <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else begin
      if (w_slot_wrap) begin
        r_slot_cnt <= '0;
        r_idx      <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_one;
      end else begin
        r_slot_cnt <= r_slot_cnt + c_slot_one;
      end
      if (w_frame_end) begin
        if (r_frame_cnt == c_frame_last) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + c_frame_one;
        end
      end
    end
  end

  // Tear-free snapshot of all display inputs, taken only at the frame boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snap_valid  <= 1'b0;
      r_snap_mode   <= NUMBER;
      r_snap_bcd    <= '0;
      r_snap_bright <= 4'hF;
    end else if (w_frame_end) begin
      r_snap_valid  <= 1'b1;
      r_snap_mode   <= select_mode(stop, semnal_stanga, semnal_dreapta);
      r_snap_bcd    <= bcd_in;
      r_snap_bright <= brightness;
    end
  end

  // Leading-zero mask: a nibble blanks while it and every nibble above it are zero;
  // the units nibble (bit 0) is never blanked
  always_comb begin : p_lead_zero
    logic w_run_zero;
    w_lead_zero = '0;
    w_run_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_run_zero     = w_run_zero & (r_snap_bcd[4*k +: 4] == 4'd0);
      w_lead_zero[k] = w_run_zero;
    end
  end

  // Glyph selection for the digit currently being scanned
  always_comb begin
    w_glyph = GLYPH_BLANK;
    if (r_snap_valid) begin
      case (r_snap_mode)
        STOP: begin
          w_glyph = DIG_8;
        end
        LEFT: begin
          if (r_idx == '0) begin
            w_glyph = r_blink_phase ? GLYPH_STANGA : GLYPH_BLANK;
          end else begin
            w_glyph = GLYPH_DASH;
          end
        end
        RIGHT: begin
          if (r_idx == c_idx_last) begin
            w_glyph = r_blink_phase ? GLYPH_DREAPTA : GLYPH_BLANK;
          end else begin
            w_glyph = GLYPH_DASH;
          end
        end
        default: begin
          if (w_lead_zero[w_pos]) begin
            w_glyph = GLYPH_BLANK;
          end else if (w_nibble > 4'd9) begin
            w_glyph = GLYPH_DASH;
          end else begin
            w_glyph = w_nibble;
          end
        end
      endcase
    end
  end

  decodor_7seg u_decodor_7seg (
    .i_glyph (w_glyph),
    .o_seg   (w_seg_next)
  );

  // PWM enable: slot 0 is dead time, then lit until the brightness-derived duty point
  always_comb begin
    w_duty     = (32'(r_snap_bright) + 32'd1) * 32'(c_duty_step);
    w_lit      = r_snap_valid && (r_slot_cnt != '0) && (32'(r_slot_cnt) < w_duty);
    w_dig_next = '0;
    if (w_lit) begin
      w_dig_next[w_pos] = 1'b1;
    end
  end

  // Registered pin drivers, one cycle behind the counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dig         <= '0;
      r_seg         <= SEG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_dig         <= w_dig_next;
      r_seg         <= w_seg_next;
      r_frame_start <= w_frame_end;
    end
  end

  assign dig         = r_dig;
  assign seg         = r_seg;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire
